// File: rtl/btn_debouncer_pkg.sv
// Shared defaults and counter sizing for the push-button conditioner.
package btn_debouncer_pkg;

    localparam int unsigned DEFAULT_DEBOUNCE      = 8;
    localparam int unsigned DEFAULT_REPEAT_DELAY  = 32;
    localparam int unsigned DEFAULT_REPEAT_PERIOD = 16;

    // Bits needed to hold values 0..max_count; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

    function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce_channel.sv
// One button channel: 2-flop synchroniser, stable-count filter, press/release strobes.
// Auto-repeat counter is built only when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_channel
    import btn_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE = DEFAULT_DEBOUNCE
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY  = DEFAULT_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEFAULT_REPEAT_PERIOD
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int unsigned CW = cnt_width(DEBOUNCE);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          differ;
    logic          flip;

    assign differ = (sync2 != level);
    assign flip   = differ && (cnt == CW'(DEBOUNCE - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1         <= 1'b0;
            sync2         <= 1'b0;
            cnt           <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync1         <= btn_raw;
            sync2         <= sync1;
            press_pulse   <= flip && !level;
            release_pulse <= flip && level;
            if (!differ || flip) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (flip) begin
                level <= ~level;
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned RW = cnt_width(max_of(REPEAT_DELAY, REPEAT_PERIOD));

    logic [RW-1:0] rc;

    // A level change takes priority so repeat never coincides with press/release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rc           <= '0;
            repeat_pulse <= 1'b0;
        end else begin
            repeat_pulse <= 1'b0;
            if (flip) begin
                rc <= level ? '0 : RW'(REPEAT_DELAY);
            end else if (!level) begin
                rc <= '0;
            end else if (rc == RW'(1)) begin
                repeat_pulse <= 1'b1;
                rc           <= RW'(REPEAT_PERIOD);
            end else if (rc != '0) begin
                rc <= rc - RW'(1);
            end
        end
    end
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/btn_debouncer.sv
// Multi-channel push-button conditioner; one independent channel per button.
// Define BTN_AUTOREPEAT_EN to build the auto-repeat strobes.
module btn_debouncer
    import btn_debouncer_pkg::*;
#(
    parameter int unsigned CHANNELS      = 2,
    parameter int unsigned DEBOUNCE      = DEFAULT_DEBOUNCE,
    parameter int unsigned REPEAT_DELAY  = DEFAULT_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEFAULT_REPEAT_PERIOD
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] btn_i,
    output logic [CHANNELS-1:0] btn_o,
    output logic [CHANNELS-1:0] press_o,
    output logic [CHANNELS-1:0] release_o,
    output logic [CHANNELS-1:0] repeat_o
);

    if (CHANNELS < 1) begin : g_bad_channels
        $error("btn_debouncer: CHANNELS must be at least 1");
    end
    if (DEBOUNCE < 1) begin : g_bad_debounce
        $error("btn_debouncer: DEBOUNCE must be at least 1");
    end

`ifdef BTN_AUTOREPEAT_EN
    if (REPEAT_DELAY < 1) begin : g_bad_delay
        $error("btn_debouncer: REPEAT_DELAY must be at least 1");
    end
    if (REPEAT_PERIOD < 1) begin : g_bad_period
        $error("btn_debouncer: REPEAT_PERIOD must be at least 1");
    end
`else
    // Repeat timing has no effect in this build.
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        btn_debounce_channel #(
            .DEBOUNCE      (DEBOUNCE)
`ifdef BTN_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .btn_raw       (btn_i[i]),
            .level         (btn_o[i]),
            .press_pulse   (press_o[i]),
            .release_pulse (release_o[i]),
            .repeat_pulse  (repeat_o[i])
        );
    end

endmodule

// File: tb/tb_btn_debouncer.sv
// Scoreboard bench for btn_debouncer: expected strobes are queued at stimulus time
// and compared against the DUT every cycle, together with the debounced levels.
module tb_btn_debouncer;

    localparam int DEB  = 8;
    localparam int RDLY = 32;
    localparam int RPER = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] btn_i = '0;
    logic [1:0] btn_o;
    logic [1:0] press_o;
    logic [1:0] release_o;
    logic [1:0] repeat_o;

    btn_debouncer #(
        .CHANNELS      (2),
        .DEBOUNCE      (DEB),
        .REPEAT_DELAY  (RDLY),
        .REPEAT_PERIOD (RPER)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_i     (btn_i),
        .btn_o     (btn_o),
        .press_o   (press_o),
        .release_o (release_o),
        .repeat_o  (repeat_o)
    );

    always #5 clk = ~clk;

    // kind: 0 = press, 1 = release, 2 = repeat
    typedef struct {
        int t;
        int kind;
        int ch;
    } ev_t;

    ev_t        sb[$];
    ev_t        ev;
    int         cyc     = 0;
    int         n_total = 0;
    int         n_bad   = 0;
    logic [1:0] exp_lvl = '0;
    logic [1:0] ep;
    logic [1:0] er;
    logic [1:0] erp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic push(input int t, input int kind, input int ch);
        ev_t e;
        int  i;
        e.t    = t;
        e.kind = kind;
        e.ch   = ch;
        i      = 0;
        while (i < sb.size() && sb[i].t <= t) i++;
        sb.insert(i, e);
    endtask

    task automatic exp_press(input int ch, input int t);
        push(t, 0, ch);
`ifdef BTN_AUTOREPEAT_EN
        for (int r = t + RDLY; r < t + 400; r += RPER) push(r, 2, ch);
`endif
    endtask

    task automatic exp_release(input int ch, input int t);
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].kind == 2 && sb[i].ch == ch && sb[i].t >= t) sb.delete(i);
        end
        push(t, 1, ch);
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called right after a falling edge: the change is seen at edge cyc+1,
    // so the filtered level moves at cyc+1+1+DEB.
    task automatic press_at(input int ch);
        btn_i[ch] = 1'b1;
        exp_press(ch, cyc + 2 + DEB);
    endtask

    task automatic release_at(input int ch);
        btn_i[ch] = 1'b0;
        exp_release(ch, cyc + 2 + DEB);
    endtask

    always @(posedge clk) begin
        cyc++;
        #1;
        ep  = '0;
        er  = '0;
        erp = '0;
        while (sb.size() > 0 && sb[0].t <= cyc) begin
            ev = sb.pop_front();
            case (ev.kind)
                0:       ep[ev.ch]  = 1'b1;
                1:       er[ev.ch]  = 1'b1;
                default: erp[ev.ch] = 1'b1;
            endcase
        end
        exp_lvl = (exp_lvl | ep) & ~er;
        check("btn_o", 32'(btn_o), 32'(exp_lvl));
        check("press_o", 32'(press_o), 32'(ep));
        check("release_o", 32'(release_o), 32'(er));
        check("repeat_o", 32'(repeat_o), 32'(erp));
    end

    initial begin
        wait_neg(3);
        rst_n = 1'b1;

        // Rise before edge 10, press at edge 19, held 100 cycles past the press.
        while (cyc != 9) @(negedge clk);
        press_at(0);
        while (cyc != 119) @(negedge clk);
        release_at(0);
        wait_neg(20);

        // 7-cycle glitch is swallowed.
        btn_i[0] = 1'b1;
        wait_neg(7);
        btn_i[0] = 1'b0;
        wait_neg(20);

        // 8-cycle pulse just qualifies.
        btn_i[0] = 1'b1;
        exp_press(0, cyc + 2 + DEB);
        wait_neg(8);
        release_at(0);
        wait_neg(20);

        // Simultaneous press, then channel 1 released alone.
        press_at(0);
        press_at(1);
        wait_neg(20);
        release_at(1);
        wait_neg(20);
        release_at(0);
        wait_neg(20);

        // Reset while channel 0 is high with a release count in progress.
        press_at(0);
        wait_neg(20);
        btn_i[0] = 1'b0;
        wait_neg(4);
        btn_i[0] = 1'b1;
        rst_n    = 1'b0;
        sb.delete();
        exp_lvl  = '0;
        wait_neg(1);
        rst_n = 1'b1;
        exp_press(0, cyc + 2 + DEB);
        wait_neg(30);
        release_at(0);
        wait_neg(30);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
